// File: rtl/vga_sync_decoder.sv
// VGA timing receiver: recovers pixel coordinates, line/frame geometry and lock state.
// Optional FRAME_CHECKSUM_EN adds a per-frame sum of active pixels on frame_sum.
module vga_sync_decoder #(
    parameter int H_ACT_START = 144,
    parameter int H_ACTIVE    = 640,
    parameter int V_ACT_START = 35,
    parameter int V_ACTIVE    = 480,
    parameter int LOCK_FRAMES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_en,
    input  logic        hsync_n,
    input  logic        vsync_n,
    input  logic [2:0]  pixel_in,
    output logic        pix_valid,
    output logic [9:0]  pix_x,
    output logic [8:0]  pix_y,
    output logic [2:0]  pix_out,
    output logic        frame_start,
    output logic        locked,
    output logic [10:0] line_len,
    output logic [9:0]  frame_lines,
    output logic        sync_err,
    output logic [15:0] frame_sum
);
    // state  | meaning
    // SEARCH | waiting for the first frame boundary
    // TRACK  | measuring reference geometry, counting matching frames
    // LOCKED | geometry stable, active pixels strobed out
    typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

    localparam logic [10:0] H_LO   = 11'(H_ACT_START);
    localparam logic [10:0] H_HI   = 11'(H_ACT_START + H_ACTIVE);
    localparam logic [9:0]  V_LO   = 10'(V_ACT_START);
    localparam logic [9:0]  V_HI   = 10'(V_ACT_START + V_ACTIVE);
    localparam logic [7:0]  LOCK_N = 8'(LOCK_FRAMES);

    state_t      state;
    logic        hs_cur, hs_prev, vs_cur, vs_prev;
    logic [2:0]  px_cur, px_d;
    logic        stb, stb_d, vs_pend;
    logic [10:0] h_cnt, ref_len, len_new;
    logic [9:0]  v_cnt, ref_lines, lines_new;
    logic [7:0]  good_cnt, cnt_inc;
    logic        first_line, ref_frame, discard;
    logic        line_start, vs_fall, frame_evt, sat_hit, len_ok, in_range;

    always_comb begin
        line_start = stb && hs_prev && !hs_cur;
        vs_fall    = stb && vs_prev && !vs_cur;
        frame_evt  = line_start && (vs_pend || vs_fall);
        len_new    = (h_cnt == 11'h7ff) ? 11'h7ff : h_cnt + 11'd1;
        lines_new  = (v_cnt == 10'h3ff) ? 10'h3ff : v_cnt + 10'd1;
        sat_hit    = stb && ((!line_start && h_cnt == 11'd2046) ||
                             (line_start && !frame_evt && v_cnt == 10'd1022));
        len_ok     = first_line || (len_new == ref_len);
        cnt_inc    = good_cnt + 8'd1;
        in_range   = (h_cnt >= H_LO) && (h_cnt < H_HI) && (v_cnt >= V_LO) && (v_cnt < V_HI);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hs_cur <= 1'b1; hs_prev <= 1'b1; vs_cur <= 1'b1; vs_prev <= 1'b1;
            px_cur <= '0; px_d <= '0; stb <= 1'b0; stb_d <= 1'b0; vs_pend <= 1'b0;
            h_cnt <= '0; v_cnt <= '0; line_len <= '0; frame_lines <= '0;
            frame_start <= 1'b0; pix_valid <= 1'b0; pix_x <= '0; pix_y <= '0; pix_out <= '0;
        end else begin
            stb   <= pix_en;
            stb_d <= stb;
            if (pix_en) begin
                hs_prev <= hs_cur;  hs_cur <= hsync_n;
                vs_prev <= vs_cur;  vs_cur <= vsync_n;
                px_cur  <= pixel_in;
            end
            frame_start <= 1'b0;
            if (stb) begin
                px_d <= px_cur;
                if (line_start) begin
                    h_cnt    <= '0;
                    line_len <= len_new;
                    if (frame_evt) begin
                        v_cnt       <= '0;
                        frame_lines <= lines_new;
                        frame_start <= 1'b1;
                    end else begin
                        v_cnt <= lines_new;
                    end
                end else begin
                    h_cnt <= len_new;
                end
                if (frame_evt)    vs_pend <= 1'b0;
                else if (vs_fall) vs_pend <= 1'b1;
            end
            // counters now reflect the sample captured two clocks ago
            pix_valid <= 1'b0;
            if (stb_d && locked && in_range) begin
                pix_valid <= 1'b1;
                pix_x     <= 10'(h_cnt - H_LO);
                pix_y     <= 9'(v_cnt - V_LO);
                pix_out   <= px_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SEARCH; locked <= 1'b0; sync_err <= 1'b0; good_cnt <= '0;
            ref_len <= '0; ref_lines <= '0; first_line <= 1'b0; ref_frame <= 1'b0; discard <= 1'b0;
        end else begin
            sync_err <= 1'b0;
            if (stb) begin
                if (sat_hit && state != SEARCH) begin
                    state <= SEARCH; locked <= 1'b0; sync_err <= 1'b1; good_cnt <= '0;
                end else begin
                    case (state)
                        SEARCH: if (frame_evt) begin
                            state <= TRACK; ref_frame <= 1'b1; first_line <= 1'b1;
                            discard <= 1'b0; good_cnt <= '0;
                        end
                        TRACK: begin
                            if (frame_evt) begin
                                if (discard) begin
                                    discard <= 1'b0; ref_frame <= 1'b1; first_line <= 1'b1; good_cnt <= '0;
                                end else if (len_ok && (ref_frame || lines_new == ref_lines)) begin
                                    if (ref_frame) ref_lines <= lines_new;
                                    ref_frame  <= 1'b0;
                                    first_line <= 1'b0;
                                    good_cnt   <= cnt_inc;
                                    if (cnt_inc == LOCK_N) begin
                                        state <= LOCKED; locked <= 1'b1;
                                    end
                                end else begin
                                    sync_err <= 1'b1; good_cnt <= '0; ref_frame <= 1'b1; first_line <= 1'b1;
                                end
                            end else if (line_start && !discard) begin
                                if (first_line) begin
                                    ref_len <= len_new; first_line <= 1'b0;
                                end else if (len_new != ref_len) begin
                                    sync_err <= 1'b1; good_cnt <= '0; discard <= 1'b1;
                                end
                            end
                        end
                        LOCKED: if (line_start && (len_new != ref_len ||
                                                   (frame_evt && lines_new != ref_lines))) begin
                            // a broken frame is discarded; the one after it becomes the new reference
                            sync_err <= 1'b1; locked <= 1'b0; state <= TRACK; good_cnt <= '0;
                            ref_frame <= 1'b1; first_line <= frame_evt; discard <= !frame_evt;
                        end
                        default: state <= SEARCH;
                    endcase
                end
            end
        end
    end

`ifdef FRAME_CHECKSUM_EN
    logic [15:0] acc;

    always_ff @(posedge clk) begin
        if (reset) begin
            acc       <= '0;
            frame_sum <= '0;
        end else if (frame_start) begin
            frame_sum <= acc + (pix_valid ? 16'(pix_out) : 16'd0);
            acc       <= '0;
        end else if (pix_valid) begin
            acc <= acc + 16'(pix_out);
        end
    end
`else
    assign frame_sum = 16'd0;
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder on a reduced 12x7 raster (6x3 active) with pix_en 1-in-4.
module tb_vga_sync_decoder;
    localparam int H0 = 4, HA = 6, V0 = 2, VA = 3;
    localparam int HT = 12, VT = 7, HS_W = 2, VS_W = 2;

    logic        clk = 1'b0;
    logic        reset, pix_en, hsync_n, vsync_n;
    logic [2:0]  pixel_in;
    logic        pix_valid, frame_start, locked, sync_err;
    logic [9:0]  pix_x;
    logic [8:0]  pix_y;
    logic [2:0]  pix_out;
    logic [10:0] line_len;
    logic [9:0]  frame_lines;
    logic [15:0] frame_sum;

    int n_assert = 0, n_fail = 0;
    int n_valid = 0, n_fs = 0, n_err = 0;
    int v0, e0, fx, fy;
    bit seen, px_const;
    longint exp_sum;

    always #5 clk = ~clk;

    vga_sync_decoder #(
        .H_ACT_START(H0), .H_ACTIVE(HA), .V_ACT_START(V0), .V_ACTIVE(VA), .LOCK_FRAMES(2)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en), .hsync_n(hsync_n), .vsync_n(vsync_n),
        .pixel_in(pixel_in), .pix_valid(pix_valid), .pix_x(pix_x), .pix_y(pix_y),
        .pix_out(pix_out), .frame_start(frame_start), .locked(locked), .line_len(line_len),
        .frame_lines(frame_lines), .sync_err(sync_err), .frame_sum(frame_sum)
    );

    // high-cycle counts of the strobes; one-clk strobes step these by one per event
    always @(negedge clk) begin
        if (pix_valid)   n_valid++;
        if (frame_start) n_fs++;
        if (sync_err)    n_err++;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
        end
    endtask

    // one pixel-clock sample, 4 clk long; output strobe for it is visible at the third negedge
    task automatic sample(input logic hs, input logic vs, input logic [2:0] px, input int s, input int l);
        @(negedge clk);
        hsync_n = hs; vsync_n = vs; pixel_in = px; pix_en = 1'b1;
        @(negedge clk);
        pix_en = 1'b0;
        @(negedge clk);
        @(negedge clk);
        if (pix_valid) begin
            chk("pix_in_active", longint'(s >= H0 && s < H0 + HA && l >= V0 && l < V0 + VA), 1);
            chk("pix_x", pix_x, s - H0);
            chk("pix_y", pix_y, l - V0);
            chk("pix_out", pix_out, px);
            if (!seen) begin
                seen = 1'b1; fx = pix_x; fy = pix_y;
            end
        end
    endtask

    task automatic send_lines(input int l0, input int l1, input int bad_line, input int bad_len, input bit vs_mid);
        for (int l = l0; l < l1; l++) begin
            int len;
            len = (l == bad_line) ? bad_len : HT;
            for (int s = 0; s < len; s++) begin
                logic vs;
                logic [2:0] px;
                vs = !((l < VS_W) || (vs_mid && l == VT - 1 && s >= 6));
                px = px_const ? 3'b100 : 3'((s * 3 + l) % 8);
                sample(s >= HS_W, vs, px, s, l);
            end
        end
    endtask

    initial begin
        reset = 1'b1; pix_en = 1'b0; hsync_n = 1'b1; vsync_n = 1'b1; pixel_in = '0;
        seen = 1'b0; px_const = 1'b0;
`ifdef FRAME_CHECKSUM_EN
        exp_sum = 72;
`else
        exp_sum = 0;
`endif
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", {pix_valid, pix_x, pix_y, pix_out, frame_start, locked,
                              line_len, frame_lines, sync_err, frame_sum}, 0);
        @(negedge clk) reset = 1'b0;
        for (int i = 0; i < 5; i++) sample(1'b1, 1'b1, 3'd0, -1, -1);

        send_lines(0, VT, -1, 0, 1'b0);
        chk("fs_after_f1", n_fs, 1);
        chk("locked_after_f1", locked, 0);
        send_lines(0, VT, -1, 0, 1'b1);
        chk("fs_after_f2", n_fs, 2);
        chk("locked_before_3rd_fs", locked, 0);

        seen = 1'b0; v0 = n_valid;
        send_lines(0, VT, -1, 0, 1'b0);
        chk("locked_at_3rd_fs", locked, 1);
        chk("line_len", line_len, HT);
        chk("frame_lines", frame_lines, VT);
        chk("valid_count_f3", n_valid - v0, HA * VA);
        chk("first_pix_x", fx, 0);
        chk("first_pix_y", fy, 0);
        chk("no_err_nominal", n_err, 0);
        chk("fs_after_f3", n_fs, 3);

        v0 = n_valid;
        send_lines(0, VT, -1, 0, 1'b1);
        chk("valid_count_f4", n_valid - v0, HA * VA);

        e0 = n_err;
        send_lines(0, VT, 3, HT - 1, 1'b0);
        chk("short_line_err", n_err - e0, 1);
        chk("short_line_unlock", locked, 0);
        send_lines(0, VT, -1, 0, 1'b0);
        send_lines(0, VT, -1, 0, 1'b0);
        chk("not_relocked_yet", locked, 0);
        px_const = 1'b1;
        send_lines(0, VT, -1, 0, 1'b0);
        chk("relocked", locked, 1);
        chk("no_extra_err", n_err - e0, 1);
        send_lines(0, VT, -1, 0, 1'b0);
        chk("frame_sum", frame_sum, exp_sum);
        px_const = 1'b0;

        e0 = n_err;
        for (int i = 0; i < 2100; i++) sample(1'b1, 1'b1, 3'd0, -1, -1);
        chk("hsat_err", n_err - e0, 1);
        chk("hsat_unlock", locked, 0);
        send_lines(0, 1, -1, 0, 1'b0);
        chk("hsat_line_len", line_len, 2047);
        send_lines(1, VT, -1, 0, 1'b0);
        send_lines(0, VT, -1, 0, 1'b0);
        chk("search_no_early_lock", locked, 0);
        send_lines(0, VT, -1, 0, 1'b0);
        chk("lock_after_search", locked, 1);
        chk("no_err_after_hsat", n_err - e0, 1);

        send_lines(0, 4, -1, 0, 1'b0);
        chk("locked_before_reset", locked, 1);
        @(negedge clk) reset = 1'b1;
        @(posedge clk);
        #1;
        chk("midframe_reset_outputs", {pix_valid, pix_x, pix_y, pix_out, frame_start, locked,
                                       line_len, frame_lines, sync_err, frame_sum}, 0);
        @(negedge clk) reset = 1'b0;
        send_lines(0, VT, -1, 0, 1'b0);
        send_lines(0, VT, -1, 0, 1'b1);
        chk("post_reset_2fs_unlocked", locked, 0);
        send_lines(0, VT, -1, 0, 1'b0);
        chk("post_reset_3fs_locked", locked, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
